mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 34 +++
 rtl/mem_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Signal bundle for mem_arbiter: two requester ports plus the shared memory command/response path.
// master = requesters and memory model side, slave = arbiter side.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    req0, req1;
  logic                    lock0, lock1;
  logic [ADDR_WIDTH-1:0]   addr0, addr1;
  logic [DATA_WIDTH-1:0]   wdata0, wdata1;
  logic [DATA_WIDTH/8-1:0] be0, be1;
  logic                    gnt0, gnt1;
  logic                    rvalid0, rvalid1;
  logic [DATA_WIDTH-1:0]   rdata;
  logic                    mem_en, mem_we;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH/8-1:0] mem_be;
  logic [DATA_WIDTH-1:0]   mem_rdata;

  modport master (
    output req0, req1, lock0, lock1, addr0, addr1, wdata0, wdata1, be0, be1,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_rdata
  );

  modport slave (
    input  req0, req1, lock0, lock1, addr0, addr1, wdata0, wdata1, be0, be1,
    output gnt0, gnt1, rvalid0, rvalid1, rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter with lock ownership and a bounded lock run length.
// MEM_ARBITER_ROUND_ROBIN_EN selects round-robin for contested idle grants; default is port 1 priority.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_LOCK   = 15
) (
  input logic          clk,
  input logic          reset_n,
  mem_arbiter_if.slave bus
);
  localparam int BE_WIDTH  = DATA_WIDTH / 8;
  localparam int CNT_WIDTH = $clog2(MAX_LOCK + 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] lock_cnt;
  logic [CNT_WIDTH-1:0] next_cnt;
  logic                 force_valid;
  logic                 force_port;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  logic                 last_port;
`endif

  logic                  owned0, owned1, contested, pick;
  logic                  sel0, sel1, gnt_any, gnt_port, gnt_lock, max_hit;
  logic [ADDR_WIDTH-1:0] gnt_addr;
  logic [DATA_WIDTH-1:0] gnt_wdata;
  logic [BE_WIDTH-1:0]   gnt_be;

  logic                  en_q, we_q, port_q, rvalid0_q, rvalid1_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [BE_WIDTH-1:0]   be_q;

  // An owner that drops req loses the lock in that same cycle, so the
  // other port is arbitrated as if the arbiter were already idle.
  always_comb begin
    owned0    = (state == OWN0) && bus.req0;
    owned1    = (state == OWN1) && bus.req1;
    contested = bus.req0 && bus.req1 && !owned0 && !owned1;
    if (force_valid) begin
      pick = force_port;
    end else begin
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      pick = ~last_port;
`else
      pick = 1'b1;
`endif
    end
    sel0      = owned0 || (!owned1 && bus.req0 && !(contested && pick));
    sel1      = owned1 || (!owned0 && bus.req1 && !(contested && !pick));
    gnt_any   = sel0 || sel1;
    gnt_port  = sel1;
    gnt_lock  = sel1 ? bus.lock1  : bus.lock0;
    gnt_addr  = sel1 ? bus.addr1  : bus.addr0;
    gnt_wdata = sel1 ? bus.wdata1 : bus.wdata0;
    gnt_be    = sel1 ? bus.be1    : bus.be0;
    next_cnt  = ((state == OWN0 && sel0) || (state == OWN1 && sel1)) ?
                lock_cnt + 1'b1 : CNT_WIDTH'(1);
    max_hit   = next_cnt >= CNT_WIDTH'(MAX_LOCK);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      lock_cnt    <= '0;
      force_valid <= 1'b0;
      force_port  <= 1'b0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      last_port   <= 1'b1;
`endif
      en_q        <= 1'b0;
      we_q        <= 1'b0;
      port_q      <= 1'b0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
    end else begin
      en_q      <= gnt_any;
      we_q      <= gnt_any && (|gnt_be);
      rvalid0_q <= en_q && !we_q && !port_q;
      rvalid1_q <= en_q && !we_q && port_q;
      if (gnt_any) begin
        addr_q  <= gnt_addr;
        wdata_q <= gnt_wdata;
        be_q    <= gnt_be;
        port_q  <= gnt_port;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        last_port <= gnt_port;
`endif
        if (contested) force_valid <= 1'b0;
        if (gnt_lock && !max_hit) begin
          state    <= gnt_port ? OWN1 : OWN0;
          lock_cnt <= next_cnt;
        end else begin
          state    <= IDLE;
          lock_cnt <= '0;
          // Exhausted lock run: the other port wins the next contested cycle.
          if (gnt_lock) begin
            force_valid <= 1'b1;
            force_port  <= ~gnt_port;
          end
        end
      end else begin
        state    <= IDLE;
        lock_cnt <= '0;
      end
    end
  end

  assign bus.gnt0      = sel0 && reset_n;
  assign bus.gnt1      = sel1 && reset_n;
  assign bus.rvalid0   = rvalid0_q;
  assign bus.rvalid1   = rvalid1_q;
  assign bus.rdata     = (rvalid0_q || rvalid1_q) ? bus.mem_rdata : '0;
  assign bus.mem_en    = en_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_be    = be_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// against a behavioural arbitration and memory model.
module tb_mem_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int BW   = DW / 8;
  localparam int MAXL = 15;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_LOCK(MAXL)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  // Synchronous memory: read data appears the cycle after the read command.
  logic [DW-1:0] phys [16];
  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) phys[i] <= '0;
    end else if (bus.mem_en) begin
      if (bus.mem_we) begin
        for (int b = 0; b < BW; b++)
          if (bus.mem_be[b]) phys[bus.mem_addr[3:0]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      end else begin
        bus.mem_rdata <= phys[bus.mem_addr[3:0]];
      end
    end
  end

  // Reference model: owner (-1 none), length of current locked run,
  // last granted port, port owed the next contested cycle (-1 none).
  typedef struct { bit v; bit rd; int port; logic [DW-1:0] data; } stage_t;
  int            m_owner, m_run, m_last, m_force;
  logic [DW-1:0] ref_mem [16];
  stage_t        st1, st2;

  task automatic model_reset();
    m_owner = -1; m_run = 0; m_last = 1; m_force = -1;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    st1 = '{v: 1'b0, rd: 1'b0, port: 0, data: '0};
    st2 = st1;
  endtask

  function automatic int model_pick(bit r0, bit r1);
    if (m_owner == 0 && r0) return 0;
    if (m_owner == 1 && r1) return 1;
    if (r0 && r1) begin
      if (m_force >= 0) return m_force;
      return RR ? 1 - m_last : 1;
    end
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  task automatic model_commit(input int g, input bit r0, input bit r1, input bit l0, input bit l1,
                              input logic [3:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be);
    bit contested;
    bit lk;
    contested = r0 && r1 && !(m_owner == 0 && r0) && !(m_owner == 1 && r1);
    st2 = st1;
    st1.v = (g >= 0);
    if (g < 0) begin
      m_owner = -1; m_run = 0;
      return;
    end
    st1.port = g;
    st1.rd   = (be == '0);
    st1.data = ref_mem[a];
    for (int b = 0; b < BW; b++) if (be[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
    if (contested) m_force = -1;
    m_last = g;
    lk = (g == 1) ? l1 : l0;
    if (lk) begin
      m_run = (m_owner == g) ? m_run + 1 : 1;
      if (m_run >= MAXL) begin
        m_owner = -1; m_run = 0; m_force = 1 - g;
      end else begin
        m_owner = g;
      end
    end else begin
      m_owner = -1; m_run = 0;
    end
  endtask

  task automatic set_port(input int p, input bit r, input bit l, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [BW-1:0] be);
    if (p == 0) begin
      bus.req0 = r; bus.lock0 = l; bus.addr0 = a; bus.wdata0 = d; bus.be0 = be;
    end else begin
      bus.req1 = r; bus.lock1 = l; bus.addr1 = a; bus.wdata1 = d; bus.be1 = be;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    set_port(0, 0, 0, '0, '0, '0);
    set_port(1, 0, 0, '0, '0, '0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    set_port(0, 1, 1, 32'h3, 32'h1234, 4'hF);
    set_port(1, 1, 0, 32'h7, 32'h5678, 4'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.gnt0, bus.gnt1} !== 2'b00) $display("FAIL reset_gnt: got %b required 00", {bus.gnt0, bus.gnt1});
    else passed++;
    checks++;
    if ({bus.rvalid0, bus.rvalid1, bus.mem_en, bus.mem_we} !== 4'b0)
      $display("FAIL reset_strobes: got %b required 0000", {bus.rvalid0, bus.rvalid1, bus.mem_en, bus.mem_we});
    else passed++;
    checks++;
    if ({bus.mem_addr, bus.mem_wdata, bus.mem_be, bus.rdata} !== '0)
      $display("FAIL reset_data: got addr %h wdata %h be %h rdata %h required all 0",
               bus.mem_addr, bus.mem_wdata, bus.mem_be, bus.rdata);
    else passed++;
    do_reset();
  endtask

  task automatic test_write_read();
    do_reset();
    set_port(0, 1, 0, 32'h10, 32'hDEADBEEF, 4'hF);
    @(negedge clk);
    checks++;
    if (bus.gnt0 !== 1'b1) $display("FAIL wr_gnt0: got %b required 1", bus.gnt0); else passed++;
    @(posedge clk); #1;
    set_port(0, 1, 0, 32'h10, 32'h0, 4'h0);
    @(negedge clk);
    checks++;
    if ({bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be} !== {2'b11, 32'h10, 32'hDEADBEEF, 4'hF})
      $display("FAIL wr_cmd: got en %b we %b addr %h wdata %h be %h required 1 1 10 deadbeef f",
               bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be);
    else passed++;
    checks++;
    if (bus.gnt0 !== 1'b1) $display("FAIL rd_gnt0: got %b required 1", bus.gnt0); else passed++;
    @(posedge clk); #1;
    set_port(0, 0, 0, '0, '0, '0);
    @(negedge clk);
    checks++;
    if ({bus.mem_en, bus.mem_we, bus.rvalid0} !== 3'b100)
      $display("FAIL rd_cmd: got en/we/rvalid0 %b required 100", {bus.mem_en, bus.mem_we, bus.rvalid0});
    else passed++;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({bus.rvalid0, bus.rvalid1, bus.rdata} !== {2'b10, 32'hDEADBEEF})
      $display("FAIL rd_data: got rvalid %b%b rdata %h required 10 deadbeef", bus.rvalid0, bus.rvalid1, bus.rdata);
    else passed++;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({bus.rvalid0, bus.mem_en} !== 2'b00)
      $display("FAIL idle_after: got rvalid0/mem_en %b required 00", {bus.rvalid0, bus.mem_en});
    else passed++;
  endtask

  task automatic test_contention();
    int n0 = 0;
    logic [1:0] exp;
    do_reset();
    set_port(0, 1, 0, 32'h1, '0, '0);
    set_port(1, 1, 0, 32'h2, '0, '0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      exp = (!RR || (i % 2 == 1)) ? 2'b10 : 2'b01;
      checks++;
      if ({bus.gnt1, bus.gnt0} !== exp)
        $display("FAIL contention cycle %0d: got gnt1/gnt0 %b required %b", i, {bus.gnt1, bus.gnt0}, exp);
      else passed++;
      if (bus.gnt0) n0++;
      @(posedge clk); #1;
    end
    set_port(0, 0, 0, '0, '0, '0);
    set_port(1, 0, 0, '0, '0, '0);
    checks++;
    if (n0 != (RR ? 4 : 0)) $display("FAIL contention_count: got %0d gnt0 required %0d", n0, RR ? 4 : 0);
    else passed++;
  endtask

  task automatic test_lock_max();
    int seq [25];
    int f = -1;
    int run = 0;
    int nxt, nxt2;
    do_reset();
    set_port(0, 1, 0, 32'h3, '0, '0);
    set_port(1, 1, 1, 32'h4, '0, '0);
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      seq[i] = {bus.gnt1, bus.gnt0};
      @(posedge clk); #1;
    end
    set_port(0, 0, 0, '0, '0, '0);
    set_port(1, 0, 0, '0, '0, '0);
    for (int i = 0; i < 25; i++) if (f < 0 && seq[i] == 2) f = i;
    checks++;
    if (f < 0) $display("FAIL lock_first: got no gnt1 required one"); else passed++;
    if (f >= 0) while (f + run < 25 && seq[f + run] == 2) run++;
    checks++;
    if (run != MAXL) $display("FAIL lock_run: got %0d consecutive gnt1 required %0d", run, MAXL);
    else passed++;
    nxt  = (f >= 0 && f + run < 25) ? seq[f + run] : -1;
    nxt2 = (f >= 0 && f + run + 1 < 25) ? seq[f + run + 1] : -1;
    checks++;
    if (nxt != 1) $display("FAIL lock_handoff: got grant code %0d required 1 (gnt0)", nxt); else passed++;
    checks++;
    if (nxt2 != 2) $display("FAIL lock_resume: got grant code %0d required 2 (gnt1)", nxt2); else passed++;
  endtask

  task automatic test_lock_release();
    do_reset();
    set_port(0, 1, 1, 32'h8, '0, '0);
    @(negedge clk);
    checks++;
    if ({bus.gnt1, bus.gnt0} !== 2'b01) $display("FAIL rel_first: got %b required 01", {bus.gnt1, bus.gnt0});
    else passed++;
    @(posedge clk); #1;
    set_port(1, 1, 0, 32'h9, '0, '0);
    @(negedge clk);
    checks++;
    if ({bus.gnt1, bus.gnt0} !== 2'b01) $display("FAIL rel_owned: got %b required 01", {bus.gnt1, bus.gnt0});
    else passed++;
    @(posedge clk); #1;
    set_port(0, 0, 1, 32'h8, '0, '0);
    @(negedge clk);
    checks++;
    if ({bus.gnt1, bus.gnt0} !== 2'b10) $display("FAIL rel_drop: got %b required 10", {bus.gnt1, bus.gnt0});
    else passed++;
    @(posedge clk); #1;
    set_port(1, 0, 0, '0, '0, '0);
  endtask

  task automatic test_reset_inflight();
    int rv0 = 0;
    int rv1 = 0;
    do_reset();
    set_port(0, 1, 0, 32'h5, '0, '0);
    @(negedge clk);
    checks++;
    if (bus.gnt0 !== 1'b1) $display("FAIL inflight_gnt: got %b required 1", bus.gnt0); else passed++;
    @(posedge clk); #1;
    set_port(0, 0, 0, '0, '0, '0);
    #1;
    checks++;
    if (bus.mem_en !== 1'b1) $display("FAIL inflight_en: got %b required 1", bus.mem_en); else passed++;
    reset_n = 1'b0;
    set_port(1, 1, 0, 32'h6, '0, '0);
    #1;
    checks++;
    if ({bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.mem_en, bus.mem_we, bus.mem_addr, bus.rdata} !== '0)
      $display("FAIL async_reset: got gnt %b%b rvalid %b%b en %b we %b addr %h rdata %h required all 0",
               bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.mem_en, bus.mem_we, bus.mem_addr, bus.rdata);
    else passed++;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.gnt1 !== 1'b1) $display("FAIL post_reset_gnt: got %b required 1", bus.gnt1); else passed++;
    @(posedge clk); #1;
    set_port(1, 0, 0, '0, '0, '0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.rvalid0) rv0++;
      if (bus.rvalid1) rv1++;
      @(posedge clk); #1;
    end
    checks++;
    if (rv0 != 0) $display("FAIL stale_rvalid0: got %0d pulses required 0", rv0); else passed++;
    checks++;
    if (rv1 != 1) $display("FAIL post_reset_rvalid1: got %0d pulses required 1", rv1); else passed++;
  endtask

  task automatic test_random();
    bit            pend [2];
    bit            rl   [2];
    logic [3:0]    ra   [2];
    logic [DW-1:0] rw   [2];
    logic [BW-1:0] rb   [2];
    logic [1:0]    eg, erv;
    int            g;
    do_reset();
    pend[0] = 0; pend[1] = 0;
    for (int c = 0; c < 10000; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 19) < (p == 1 ? 19 : 14)) begin
          pend[p] = 1;
          ra[p]   = 4'($urandom_range(0, 15));
          rw[p]   = $urandom;
          rb[p]   = $urandom_range(0, 1) ? BW'($urandom) : '0;
          rl[p]   = $urandom_range(0, 9) < (p == 1 ? 9 : 5);
        end
        set_port(p, pend[p], rl[p], AW'(ra[p]), rw[p], rb[p]);
      end
      @(negedge clk);
      g   = model_pick(pend[0], pend[1]);
      eg  = {g == 1, g == 0};
      erv = (st2.v && st2.rd) ? {st2.port == 1, st2.port == 0} : 2'b00;
      checks++;
      if ({bus.gnt1, bus.gnt0} !== eg)
        $display("FAIL rand_gnt cycle %0d: got %b required %b", c, {bus.gnt1, bus.gnt0}, eg);
      else passed++;
      checks++;
      if (bus.gnt0 && bus.gnt1) $display("FAIL rand_dual cycle %0d: got 11 required at most one", c);
      else passed++;
      checks++;
      if (bus.mem_en !== st1.v) $display("FAIL rand_en cycle %0d: got %b required %b", c, bus.mem_en, st1.v);
      else passed++;
      checks++;
      if ({bus.rvalid1, bus.rvalid0} !== erv)
        $display("FAIL rand_rvalid cycle %0d: got %b required %b", c, {bus.rvalid1, bus.rvalid0}, erv);
      else passed++;
      if (erv != 2'b00) begin
        checks++;
        if (bus.rdata !== st2.data)
          $display("FAIL rand_rdata cycle %0d: got %h required %h", c, bus.rdata, st2.data);
        else passed++;
      end
      if (g >= 0) model_commit(g, pend[0], pend[1], rl[0], rl[1], ra[g], rw[g], rb[g]);
      else model_commit(g, pend[0], pend[1], rl[0], rl[1], '0, '0, '0);
      if (g >= 0) pend[g] = 0;
      @(posedge clk); #1;
    end
    set_port(0, 0, 0, '0, '0, '0);
    set_port(1, 0, 0, '0, '0, '0);
  endtask

  initial begin
    reset_n = 1'b0;
    set_port(0, 0, 0, '0, '0, '0);
    set_port(1, 0, 0, '0, '0, '0);
    model_reset();
    test_reset();
    test_write_read();
    test_contention();
    test_lock_max();
    test_lock_release();
    test_reset_inflight();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks so far", passed, checks);
    $fatal(1, "watchdog expired");
  end
endmodule
